// File: rtl/math_game_core.sv
// rtl/math_game_core.sv - mental-arithmetic game core: shows LFSR terms, folds them mod 100, scores the answer
`timescale 1ns/1ps
module math_game_core #(
    parameter int NUM_TERMS  = 5,
    parameter int TERM_W     = 5,
    parameter int SHOW_CYC   = 1,
    parameter int ANSWER_CYC = 15,
    parameter int RESULT_CYC = 4,
    parameter int SCORE_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic [TERM_W-1:0]  seed,
    input  logic [6:0]         switch,
    output logic [6:0]         value,
    output logic [6:0]         led,
    output logic               busy,
    output logic               result_valid,
    output logic               correct,
    output logic [SCORE_W-1:0] score
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHOW,
        S_BLANK,
        S_ANSWER,
        S_RESULT
    } state_t;

    localparam int MAX_CYC = (SHOW_CYC > ANSWER_CYC) ?
                             ((SHOW_CYC > RESULT_CYC) ? SHOW_CYC : RESULT_CYC) :
                             ((ANSWER_CYC > RESULT_CYC) ? ANSWER_CYC : RESULT_CYC);
    localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    // Second feedback tap: width 5 uses bit 2, widths 4 and 6 use the bit below the MSB
    localparam int TAP = (TERM_W == 5) ? 2 : TERM_W - 2;
    // Non-zero fallback pattern 1010...1, also the reset value of the LFSR
    localparam logic [TERM_W-1:0] ALT_PAT = TERM_W'(32'h5555_5555);

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [3:0]         r_idx, w_idx_nxt;
    logic [TERM_W-1:0]  r_lfsr, w_lfsr_nxt;
    logic [6:0]         r_sum, w_sum_nxt;
    logic               r_mode, w_mode_nxt;
    logic [6:0]         r_answer, w_answer_nxt;
    logic [6:0]         r_value, w_value_nxt;
    logic [6:0]         r_led, w_led_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_rv, w_rv_nxt;
    logic               r_correct, w_correct_nxt;
    logic [SCORE_W-1:0] r_score, w_score_nxt;

    logic [TERM_W-1:0]  w_lfsr_step;
    logic [7:0]         w_add_full;
    logic [6:0]         w_term7;
    logic [6:0]         w_add7;
    logic [6:0]         w_sub7;
    logic [6:0]         w_folded;
    logic               w_op_sub;
    logic               w_match;

    // Term folding: sum stays in 0..99; 7-bit wraparound arithmetic is exact because results never leave that range
    always_comb begin
        w_lfsr_step = {r_lfsr[TERM_W-2:0], r_lfsr[TERM_W-1] ^ r_lfsr[TAP]};
        w_term7     = {{(7-TERM_W){1'b0}}, r_lfsr};
        w_add_full  = {1'b0, r_sum} + {1'b0, w_term7};
        w_add7      = (w_add_full >= 8'd100) ? (r_sum + w_term7 - 7'd100) : (r_sum + w_term7);
        w_sub7      = (r_sum < w_term7) ? (r_sum - w_term7 + 7'd100) : (r_sum - w_term7);
        w_op_sub    = r_mode && r_idx[0];
        w_folded    = w_op_sub ? w_sub7 : w_add7;
        w_match     = (switch == r_sum);
    end

    // Next-state, datapath updates and next registered outputs
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_lfsr_nxt    = r_lfsr;
        w_sum_nxt     = r_sum;
        w_mode_nxt    = r_mode;
        w_answer_nxt  = r_answer;
        w_correct_nxt = r_correct;
        w_score_nxt   = r_score;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_lfsr_nxt  = (seed == '0) ? ALT_PAT : seed;
                    w_sum_nxt   = 7'd0;
                    w_idx_nxt   = 4'd0;
                    w_cnt_nxt   = '0;
                    w_mode_nxt  = mode;
                    w_state_nxt = S_SHOW;
                end
            end
            S_SHOW: begin
                if (r_cnt == CNT_W'(SHOW_CYC - 1)) begin
                    w_cnt_nxt  = '0;
                    w_sum_nxt  = w_folded;
                    w_lfsr_nxt = w_lfsr_step;
                    w_idx_nxt  = r_idx + 4'd1;
                    if (r_idx == 4'(NUM_TERMS - 1)) begin
                        w_state_nxt = S_BLANK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_BLANK: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_ANSWER;
            end
            S_ANSWER: begin
                if (r_cnt == CNT_W'(ANSWER_CYC - 1)) begin
                    w_cnt_nxt     = '0;
                    w_answer_nxt  = switch;
                    w_correct_nxt = w_match;
                    if (w_match && (r_score != {SCORE_W{1'b1}})) begin
                        w_score_nxt = r_score + 1'b1;
                    end
                    w_state_nxt = S_RESULT;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RESULT: begin
                w_correct_nxt = (r_answer == r_sum);
                if (r_cnt == CNT_W'(RESULT_CYC - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase

        w_value_nxt = 7'd0;
        w_led_nxt   = 7'd0;
        case (w_state_nxt)
            S_SHOW: begin
                w_value_nxt = {{(7-TERM_W){1'b0}}, w_lfsr_nxt};
                w_led_nxt   = {{(7-TERM_W){1'b0}}, w_lfsr_nxt};
            end
            S_ANSWER: begin
                w_value_nxt = switch;
            end
            S_RESULT: begin
                w_value_nxt = w_sum_nxt;
                w_led_nxt   = w_correct_nxt ? 7'b1111111 : 7'b1010101;
            end
            default: begin
                w_value_nxt = 7'd0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_rv_nxt   = (w_state_nxt == S_RESULT);
    end

    // State and output registers; reset wins over everything including a round in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= 4'd0;
            r_lfsr    <= ALT_PAT;
            r_sum     <= 7'd0;
            r_mode    <= 1'b0;
            r_answer  <= 7'd0;
            r_value   <= 7'd0;
            r_led     <= 7'd0;
            r_busy    <= 1'b0;
            r_rv      <= 1'b0;
            r_correct <= 1'b0;
            r_score   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_lfsr    <= w_lfsr_nxt;
            r_sum     <= w_sum_nxt;
            r_mode    <= w_mode_nxt;
            r_answer  <= w_answer_nxt;
            r_value   <= w_value_nxt;
            r_led     <= w_led_nxt;
            r_busy    <= w_busy_nxt;
            r_rv      <= w_rv_nxt;
            r_correct <= w_correct_nxt;
            r_score   <= w_score_nxt;
        end
    end

    assign value        = r_value;
    assign led          = r_led;
    assign busy         = r_busy;
    assign result_valid = r_rv;
    assign correct      = r_correct;
    assign score        = r_score;

endmodule

// File: tb/tb_math_game_core.sv
// tb/tb_math_game_core.sv - randomized self-checking bench for math_game_core against a mod-100 round model
`timescale 1ns/1ps
module tb_math_game_core;

    localparam int NT = 5;
    localparam int AC = 15;
    localparam int RC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
    logic [4:0] seed;
    logic [6:0] switch;
    logic [6:0] value, value2;
    logic [6:0] led, led2;
    logic       busy, busy2;
    logic       result_valid, result_valid2;
    logic       correct, correct2;
    logic [3:0] score;
    logic [1:0] score2;

    int n_checks = 0;
    int n_pass   = 0;
    int m_terms[16];
    int m_sum;
    int ms4 = 0;
    int ms2 = 0;

    always #5 clk = ~clk;

    math_game_core #(.NUM_TERMS(NT), .TERM_W(5), .SHOW_CYC(1), .ANSWER_CYC(AC),
                     .RESULT_CYC(RC), .SCORE_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed), .switch(switch),
        .value(value), .led(led), .busy(busy), .result_valid(result_valid),
        .correct(correct), .score(score));

    math_game_core #(.NUM_TERMS(NT), .TERM_W(5), .SHOW_CYC(1), .ANSWER_CYC(AC),
                     .RESULT_CYC(RC), .SCORE_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed), .switch(switch),
        .value(value2), .led(led2), .busy(busy2), .result_valid(result_valid2),
        .correct(correct2), .score(score2));

    // Reference: terms from the 5-bit recurrence, sum kept modulo 100
    task automatic build_model(input int sd, input int md);
        int t;
        int s;
        t = (sd == 0) ? 21 : sd;
        s = 0;
        for (int k = 0; k < NT; k++) begin
            m_terms[k] = t;
            if (md != 0 && (k % 2) == 1) s = (s - t + 100) % 100;
            else                         s = (s + t) % 100;
            t = (t * 2 + (((t >> 4) ^ (t >> 2)) & 1)) % 32;
        end
        m_sum = s;
    endtask

    task automatic run_round(input string name, input int sd, input int md,
                             input bit make_correct, input int sw_rand, input bit glitch);
        logic [6:0] ev, el, esw;
        logic       eb, er, ec;
        int         last;
        last = NT + AC + RC + 1;
        build_model(sd, md);
        esw = make_correct ? 7'(m_sum) : 7'(sw_rand);
        ec  = (int'(esw) == m_sum);
        @(negedge clk);
        seed = 5'(sd); mode = md[0]; switch = esw; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c <= last; c++) begin
            ev = 7'd0; el = 7'd0; eb = 1'b1; er = 1'b0;
            if (c < NT) begin
                ev = 7'(m_terms[c]); el = 7'(m_terms[c]);
            end else if (c == NT) begin
                ev = 7'd0;
            end else if (c <= NT + AC) begin
                ev = esw;
            end else if (c <= NT + AC + RC) begin
                ev = 7'(m_sum); el = ec ? 7'b1111111 : 7'b1010101; er = 1'b1;
                if (c == NT + AC + 1 && ec) begin
                    ms4 = (ms4 < 15) ? ms4 + 1 : 15;
                    ms2 = (ms2 < 3) ? ms2 + 1 : 3;
                end
            end else begin
                eb = 1'b0;
            end
            if (value !== ev) $display("FAIL %s c%0d value got %0d exp %0d", name, c, value, ev); else n_pass++;
            n_checks++;
            if (led !== el) $display("FAIL %s c%0d led got %b exp %b", name, c, led, el); else n_pass++;
            n_checks++;
            if (busy !== eb) $display("FAIL %s c%0d busy got %b exp %b", name, c, busy, eb); else n_pass++;
            n_checks++;
            if (result_valid !== er) $display("FAIL %s c%0d result_valid got %b exp %b", name, c, result_valid, er); else n_pass++;
            n_checks++;
            if (score !== 4'(ms4)) $display("FAIL %s c%0d score got %0d exp %0d", name, c, score, ms4); else n_pass++;
            n_checks++;
            if (score2 !== 2'(ms2)) $display("FAIL %s c%0d score2 got %0d exp %0d", name, c, score2, ms2); else n_pass++;
            n_checks++;
            if (er) begin
                if (correct !== ec) $display("FAIL %s c%0d correct got %b exp %b", name, c, correct, ec); else n_pass++;
                n_checks++;
            end
            start = (glitch && c == NT + 2) ? 1'b1 : 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 1'b0; seed = 5'd0; switch = 7'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        if (value !== 7'd0) $display("FAIL reset value got %0d exp 0", value); else n_pass++;
        n_checks++;
        if (led !== 7'd0) $display("FAIL reset led got %0d exp 0", led); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset busy got %b exp 0", busy); else n_pass++;
        n_checks++;
        if (result_valid !== 1'b0) $display("FAIL reset result_valid got %b exp 0", result_valid); else n_pass++;
        n_checks++;
        if (correct !== 1'b0) $display("FAIL reset correct got %b exp 0", correct); else n_pass++;
        n_checks++;
        if (score !== 4'd0) $display("FAIL reset score got %0d exp 0", score); else n_pass++;
        n_checks++;
        rst = 1'b0;
        ms4 = 0; ms2 = 0;
    endtask

    task automatic test_add();
        run_round("add_seed1", 1, 0, 1'b0, 34, 1'b0);
    endtask

    task automatic test_sub();
        run_round("sub_seed1", 1, 1, 1'b0, 34, 1'b0);
    endtask

    task automatic test_seed_zero();
        run_round("seed_zero", 0, int'($urandom_range(0, 1)), 1'b1, 0, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_round("start_in_answer", int'($urandom_range(1, 31)), 0, 1'b1, 0, 1'b1);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        seed = 5'd9; mode = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ms4 = 0; ms2 = 0;
        if (value !== 7'd0) $display("FAIL mid_reset value got %0d exp 0", value); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL mid_reset busy got %b exp 0", busy); else n_pass++;
        n_checks++;
        if (score !== 4'd0) $display("FAIL mid_reset score got %0d exp 0", score); else n_pass++;
        n_checks++;
        if (score2 !== 2'd0) $display("FAIL mid_reset score2 got %0d exp 0", score2); else n_pass++;
        n_checks++;
        run_round("replay_after_reset", 9, 0, 1'b0, 127, 1'b0);
    endtask

    task automatic test_saturate();
        for (int r = 0; r < 4; r++) begin
            run_round("saturate", int'($urandom_range(0, 31)), int'($urandom_range(0, 1)), 1'b1, 0, 1'b0);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            run_round("random", int'($urandom_range(0, 31)), int'($urandom_range(0, 1)),
                      $urandom_range(0, 1) == 1, int'($urandom_range(0, 127)), $urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_seed_zero();
        test_start_ignored();
        test_mid_reset();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/math_game_core.md
MATH_GAME_CORE -- requirements
Module: math_game_core

Interface
REQ-001 SHALL have parameter NUM_TERMS, default 5: random terms shown per round, legal range 1..15.
REQ-002 SHALL have parameter TERM_W, default 5: LFSR/term width, legal values 4, 5, 6.
REQ-003 SHALL have parameter SHOW_CYC, default 1: cycles each term is displayed, at least 1.
REQ-004 SHALL have parameter ANSWER_CYC, default 15: answer-entry window in cycles, at least 1.
REQ-005 SHALL have parameter RESULT_CYC, default 4: result display window in cycles, at least 1.
REQ-006 SHALL have parameter SCORE_W, default 4: width of the score counter.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port start, input, 1 bit: round request, sampled in IDLE only.
REQ-010 SHALL have port mode, input, 1 bit: 0 = all terms added; 1 = alternate add/subtract.
REQ-011 SHALL have port seed, input, TERM_W bits: LFSR seed.
REQ-012 SHALL have port switch, input, 7 bits: user answer.
REQ-013 SHALL have port value, output, 7 bits: binary display value, 0..99, feeding the BCD converter.
REQ-014 SHALL have port led, output, 7 bits: LED pattern.
REQ-015 SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-016 SHALL have port result_valid, output, 1 bit: high in RESULT only.
REQ-017 SHALL have port correct, output, 1 bit: comparison outcome, meaningful while result_valid is high.
REQ-018 SHALL have port score, output, SCORE_W bits: count of correct rounds.

Function
REQ-019 The FSM SHALL have the states IDLE, SHOW, BLANK, ANSWER, RESULT, all registered outputs.
REQ-020 When start is high in IDLE, the block SHALL, on the same edge:
  - load lfsr with seed, or with alternating 1010... (LSB = 1) if seed is zero;
  - clear sum and the term index;
  - latch mode;
  - enter SHOW.
REQ-021 A start pulse seen outside IDLE SHALL be ignored; it SHALL NOT be queued.
REQ-022 In SHOW, value and led SHALL both equal lfsr, zero-extended to 7 bits.
REQ-023 On the last cycle of each SHOW_CYC window, the block SHALL:
  - fold lfsr into sum;
  - step lfsr;
  - increment the term index.
REQ-024 The LFSR step SHALL be a left shift with feedback into bit 0:
  - TERM_W = 4: bit3 ^ bit2;
  - TERM_W = 5: bit4 ^ bit2;
  - TERM_W = 6: bit5 ^ bit4.
REQ-025 sum SHALL be 7 bits and always held in 0..99.
REQ-026 Add: if sum + term >= 100, the result SHALL be sum + term - 100; otherwise sum + term.
REQ-027 Subtract: if sum < term, the result SHALL be sum - term + 100; otherwise sum - term.
REQ-028 Operation selection SHALL be:
  - term index 0: always add;
  - latched mode 0: every term added;
  - latched mode 1: odd index subtract, even index add.
REQ-029 After term NUM_TERMS-1 is folded, the FSM SHALL spend exactly 1 cycle in BLANK with value = 0 and led = 0.
REQ-030 In ANSWER (ANSWER_CYC cycles), value SHALL equal switch, and led SHALL equal 0.
REQ-031 On the last ANSWER cycle, switch SHALL be captured as the answer.
REQ-032 In RESULT (RESULT_CYC cycles):
  - value SHALL equal sum;
  - correct SHALL be (answer == sum);
  - led SHALL be 7'b1111111 if correct, otherwise 7'b1010101.
REQ-033 On the edge entering RESULT, if the answer is correct, score SHALL increment by 1, saturating at all-ones.
REQ-034 After RESULT, the FSM SHALL return to IDLE.
REQ-035 In IDLE, value and led SHALL be 0; score and sum SHALL hold.
REQ-036 A new start in IDLE SHALL clear sum but SHALL NOT clear score.

Reset
REQ-037 On rst high at a clock edge, the block SHALL enter IDLE and clear to 0:
  - value, led, sum, answer, term index, cycle counters;
  - busy, result_valid, correct, score.
REQ-038 rst SHALL take priority over start and over any state, including mid-round.
REQ-039 lfsr SHALL reset to the non-zero default pattern.

Verification
REQ-040 Defaults, mode = 0, seed = 5'b00001, start pulse:
  - SHOW displays 1, 2, 4, 9, 18 on consecutive cycles;
  - BLANK shows 0;
  - sum = 34;
  - switch = 34 -> correct = 1, led = 1111111, score 0 -> 1.
REQ-041 Same seed, mode = 1:
  - sum sequence 1, 99, 3, 94, 12;
  - switch = 34 -> correct = 0, led = 1010101, score unchanged.
REQ-042 seed = 0, start:
  - first displayed term is 21 (5'b10101), never 0.
REQ-043 Start pulse during ANSWER:
  - ignored; round timing unchanged;
  - busy = 1 throughout;
  - busy falls exactly after RESULT_CYC result cycles.
REQ-044 SCORE_W = 2, four correct rounds:
  - score 1, 2, 3, 3 (saturated).
REQ-045 rst asserted in the middle of SHOW:
  - next cycle IDLE, value = 0, score = 0, busy = 0;
  - a following start replays the seed sequence from term 0.
